// File: rtl/spi_master_engine_if.sv
// Bundle of the CPU-side request/response signals and the SPI wires of the
// SPI master engine. The master modport is the engine itself; the slave
// modport is whatever sits on the other side (register block plus SPI slave).
interface spi_master_engine_if #(
    parameter int W_DATA = 32
);
    logic              start;
    logic [W_DATA-1:0] tx_data;
    logic              miso;
    logic              busy;
    logic              dv;
    logic [W_DATA-1:0] rx_data;
    logic              sclk;
    logic              cs_n;
    logic              mosi;

    modport master (
        input  start, tx_data, miso,
        output busy, dv, rx_data, sclk, cs_n, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, dv, rx_data, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master_engine.sv
// SPI mode 0 (CPOL=0, CPHA=0, MSB first) single-word master engine.
//
// Handshake: start is a level request sampled only in IDLE; the edge that
// samples it high is the accepting edge and latches tx_data. busy is high
// from that edge until the completion edge, and while busy any start is
// ignored. At completion rx_data is updated and dv pulses for exactly one
// cycle; rx_data is then held until the next completion.
module spi_master_engine #(
    parameter int W_DATA  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_master_engine_if.master   bus,
    output logic [1:0]            state_dbg
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (W_DATA > 1) ? $clog2(W_DATA) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [W_DATA-1:0]   tx_q, tx_d;
    logic [W_DATA-1:0]   rx_q, rx_d;
    logic [W_DATA-1:0]   rx_data_q, rx_data_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                dv_q, dv_d;

    logic                div_done;
    logic                last_bit;

    // One half-period of sclk has elapsed; the bit counter is on the final bit.
    assign div_done = (div_q == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_q == BIT_W'(W_DATA - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset mid-transfer aborts everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            dv_q      <= dv_d;
        end
    end

    // Next-state: SETUP and HOLD last one half-period each; SHIFT ends after
    // the falling transition of the last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   if (div_done) state_d = SHIFT;
            SHIFT:   if (div_done && sclk_q && last_bit) state_d = HOLD;
            HOLD:    if (div_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath: rising transitions sample miso, falling
    // transitions shift tx and present the next bit on mosi.
    always_comb begin
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        dv_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_d   = bus.tx_data;
                    mosi_d = bus.tx_data[W_DATA-1];
                    cs_n_d = 1'b0;
                    busy_d = 1'b1;
                    div_d  = '0;
                    bit_d  = '0;
                end
            end
            SETUP: begin
                if (div_done) begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[W_DATA-2:0], bus.miso};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_d = '0;
                    if (sclk_q) begin
                        // After the last bit the zero fill reaches bit W-2.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[W_DATA-2:0], 1'b0};
                        mosi_d = tx_q[W_DATA-2];
                        if (!last_bit) begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[W_DATA-2:0], bus.miso};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_done) begin
                    div_d     = '0;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    dv_d      = 1'b1;
                    rx_data_d = rx_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                div_d = '0;
            end
        endcase
    end

    assign bus.sclk    = sclk_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.dv      = dv_q;
    assign bus.rx_data = rx_data_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: one instance with CLK_DIV=4 and one with
// CLK_DIV=1, observed through a selectable monitor that records sclk rises,
// the mosi bit seen at each rise and any mosi change while sclk is high.
module tb_spi_master_engine;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_engine_if #(.W_DATA(W)) if4 ();
    spi_master_engine_if #(.W_DATA(W)) if1 ();
    logic [1:0] st4, st1;

    spi_master_engine #(.W_DATA(W), .CLK_DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.master), .state_dbg(st4)
    );
    spi_master_engine #(.W_DATA(W), .CLK_DIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master), .state_dbg(st1)
    );

    // Stimulus
    logic         sel = 1'b0;       // 0: CLK_DIV=4 instance, 1: CLK_DIV=1
    logic         start_v = 1'b0;
    logic [W-1:0] tx_v = '0;
    int           miso_mode = 0;    // 0 loopback, 1 tied high, 2 tied low, 3 pattern
    logic [W-1:0] pat = '0;
    int           pat_base = 0;
    logic         pat_bit;

    int           n_cmp = 0;
    int           n_bad = 0;

    // Monitor state
    int           rises = 0;
    int           hold_viol = 0;
    int           mosi_high = 0;
    int           dv_seen = 0;
    logic         sclk_prev = 1'b0;
    logic         mosi_prev = 1'b0;
    logic [W-1:0] mosi_word = '0;

    // Pattern word driven MSB first, advancing after each observed sclk rise.
    always_comb begin
        int idx;
        idx = rises - pat_base;
        pat_bit = 1'b0;
        if (idx >= 0 && idx < W) pat_bit = pat[W-1-idx];
    end

    assign if4.start   = start_v & ~sel;
    assign if1.start   = start_v & sel;
    assign if4.tx_data = tx_v;
    assign if1.tx_data = tx_v;
    assign if4.miso = (miso_mode == 0) ? if4.mosi : (miso_mode == 1) ? 1'b1 :
                      (miso_mode == 2) ? 1'b0 : pat_bit;
    assign if1.miso = (miso_mode == 0) ? if1.mosi : (miso_mode == 1) ? 1'b1 :
                      (miso_mode == 2) ? 1'b0 : pat_bit;

    logic         m_sclk, m_mosi, m_dv, m_busy, m_cs_n;
    logic [W-1:0] m_rx;
    assign m_sclk = sel ? if1.sclk    : if4.sclk;
    assign m_mosi = sel ? if1.mosi    : if4.mosi;
    assign m_dv   = sel ? if1.dv      : if4.dv;
    assign m_busy = sel ? if1.busy    : if4.busy;
    assign m_cs_n = sel ? if1.cs_n    : if4.cs_n;
    assign m_rx   = sel ? if1.rx_data : if4.rx_data;

    always @(negedge clk) begin
        if (m_sclk && !sclk_prev) begin
            rises     <= rises + 1;
            mosi_word <= {mosi_word[W-2:0], m_mosi};
        end
        if (m_sclk && sclk_prev && (m_mosi !== mosi_prev)) hold_viol <= hold_viol + 1;
        if (m_mosi === 1'b1) mosi_high <= mosi_high + 1;
        if (m_dv === 1'b1) dv_seen <= dv_seen + 1;
        sclk_prev <= m_sclk;
        mosi_prev <= m_mosi;
    end

    // Request one transfer; returns at the first negedge after the accepting
    // edge, then scrambles tx_data to show later changes are ignored.
    task automatic start_xfer(input logic [W-1:0] w);
        @(negedge clk);
        tx_v = w;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        tx_v = $urandom;
    endtask

    // Count cycles from the accepting edge until dv is seen, bounded.
    task automatic wait_dv(input int lat0, input int budget, output int lat);
        lat = lat0;
        while (lat < budget && m_dv !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (if4.cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b want 1", if4.cs_n); end
        n_cmp++; if (if4.sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", if4.sclk); end
        n_cmp++; if (if4.mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b want 0", if4.mosi); end
        n_cmp++; if (if4.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", if4.busy); end
        n_cmp++; if (if4.dv !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b want 0", if4.dv); end
        n_cmp++; if (if4.rx_data !== '0) begin n_bad++; $display("FAIL reset_rx_data: got %h want 0", if4.rx_data); end
        n_cmp++; if (st4 !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st4); end
        n_cmp++; if (if1.cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n_div1: got %b want 1", if1.cs_n); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Full transfer on the CLK_DIV=4 instance; miso source chosen by caller.
    task automatic run_div4(input logic [W-1:0] w, input logic [W-1:0] exp_rx, input string name);
        int lat, r0, hv0;
        sel = 1'b0;
        r0 = rises;
        hv0 = hold_viol;
        start_xfer(w);
        wait_dv(0, 400, lat);
        n_cmp++; if (lat !== 260) begin n_bad++; $display("FAIL %s_latency: got %0d want 260", name, lat); end
        n_cmp++; if (m_rx !== exp_rx) begin n_bad++; $display("FAIL %s_rx_data: got %h want %h", name, m_rx, exp_rx); end
        n_cmp++; if (m_busy !== 1'b0 || m_cs_n !== 1'b1) begin n_bad++; $display("FAIL %s_idle_at_dv: busy %b cs_n %b want 0/1", name, m_busy, m_cs_n); end
        n_cmp++; if (rises - r0 !== W) begin n_bad++; $display("FAIL %s_sclk_pulses: got %0d want %0d", name, rises - r0, W); end
        n_cmp++; if (mosi_word !== w) begin n_bad++; $display("FAIL %s_mosi_bits: got %h want %h", name, mosi_word, w); end
        n_cmp++; if (hold_viol !== hv0) begin n_bad++; $display("FAIL %s_mosi_stable: got %0d changes want 0", name, hold_viol - hv0); end
        @(negedge clk);
        n_cmp++; if (m_dv !== 1'b0) begin n_bad++; $display("FAIL %s_dv_width: got %b want 0", name, m_dv); end
    endtask

    task automatic test_loopback();
        logic [W-1:0] w;
        miso_mode = 0;
        run_div4(32'hA5A5_0F0F, 32'hA5A5_0F0F, "loopback");
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            run_div4(w, w, "loopback_rand");
        end
    endtask

    task automatic test_miso_const();
        int mh0;
        logic [W-1:0] w;
        miso_mode = 1;
        mh0 = mosi_high;
        run_div4('0, '1, "miso_high");
        n_cmp++; if (mosi_high !== mh0) begin n_bad++; $display("FAIL miso_high_mosi_zero: got %0d high cycles want 0", mosi_high - mh0); end
        miso_mode = 2;
        w = $urandom;
        run_div4(w, '0, "miso_low");
    endtask

    task automatic test_random_miso();
        logic [W-1:0] w;
        miso_mode = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pat = $urandom;
            pat_base = rises;
            w = $urandom;
            run_div4(w, pat, "miso_pattern");
        end
    endtask

    task automatic test_busy_protect();
        int lat, r0;
        sel = 1'b0;
        miso_mode = 0;
        r0 = rises;
        start_xfer(32'hA5A5_0F0F);
        repeat (99) @(negedge clk);
        tx_v = 32'h1234_5678;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        wait_dv(100, 400, lat);
        n_cmp++; if (lat !== 260) begin n_bad++; $display("FAIL busy_latency: got %0d want 260", lat); end
        n_cmp++; if (m_rx !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL busy_rx_data: got %h want a5a50f0f", m_rx); end
        n_cmp++; if (mosi_word !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL busy_mosi_bits: got %h want a5a50f0f", mosi_word); end
        n_cmp++; if (rises - r0 !== W) begin n_bad++; $display("FAIL busy_sclk_pulses: got %0d want %0d", rises - r0, W); end
        repeat (10) @(negedge clk);
        n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL busy_no_queued_start: got %b want 0", m_busy); end
    endtask

    task automatic test_abort();
        int dv0;
        sel = 1'b0;
        miso_mode = 0;
        start_xfer(32'hA5A5_0F0F);
        dv0 = dv_seen;
        repeat (49) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (if4.cs_n !== 1'b1 || if4.sclk !== 1'b0) begin n_bad++; $display("FAIL abort_wires: cs_n %b sclk %b want 1/0", if4.cs_n, if4.sclk); end
        n_cmp++; if (if4.busy !== 1'b0 || if4.mosi !== 1'b0) begin n_bad++; $display("FAIL abort_busy_mosi: busy %b mosi %b want 0/0", if4.busy, if4.mosi); end
        n_cmp++; if (if4.rx_data !== '0) begin n_bad++; $display("FAIL abort_rx_data: got %h want 0", if4.rx_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        n_cmp++; if (dv_seen !== dv0) begin n_bad++; $display("FAIL abort_no_dv: got %0d pulses want 0", dv_seen - dv0); end
        run_div4(32'h0000_FFFF, 32'h0000_FFFF, "after_abort");
    endtask

    task automatic test_streaming();
        logic [W-1:0] words[4];
        logic [W-1:0] exp_q[$];
        logic [W-1:0] exp_w;
        int lat, r0;
        sel = 1'b1;
        miso_mode = 0;
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            exp_q.push_back(words[i]);
        end
        @(negedge clk);
        tx_v = words[0];
        start_v = 1'b1;
        r0 = rises;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            wait_dv(0, 200, lat);
            exp_w = exp_q.pop_front();
            n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL stream_latency[%0d]: got %0d want 65", k, lat); end
            n_cmp++; if (m_rx !== exp_w) begin n_bad++; $display("FAIL stream_rx_data[%0d]: got %h want %h", k, m_rx, exp_w); end
            n_cmp++; if (mosi_word !== exp_w) begin n_bad++; $display("FAIL stream_mosi_bits[%0d]: got %h want %h", k, mosi_word, exp_w); end
            n_cmp++; if (rises - r0 !== W) begin n_bad++; $display("FAIL stream_sclk_pulses[%0d]: got %0d want %0d", k, rises - r0, W); end
            n_cmp++; if (m_cs_n !== 1'b1) begin n_bad++; $display("FAIL stream_cs_gap[%0d]: got %b want 1", k, m_cs_n); end
            r0 = rises;
            if (k < 3) tx_v = words[k+1];
            else start_v = 1'b0;
            @(negedge clk);
            n_cmp++; if (m_dv !== 1'b0) begin n_bad++; $display("FAIL stream_dv_width[%0d]: got %b want 0", k, m_dv); end
            if (k < 3) begin
                n_cmp++; if (m_cs_n !== 1'b0 || m_busy !== 1'b1) begin n_bad++; $display("FAIL stream_reaccept[%0d]: cs_n %b busy %b want 0/1", k, m_cs_n, m_busy); end
            end else begin
                n_cmp++; if (m_cs_n !== 1'b1 || m_busy !== 1'b0 || st1 !== 2'd0) begin n_bad++; $display("FAIL stream_stop: cs_n %b busy %b state %0d want 1/0/0", m_cs_n, m_busy, st1); end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_miso_const();
        test_random_miso();
        test_busy_protect();
        test_abort();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
